// File: rtl/tmp_code_acc.sv
//------------------------------------------------------------------------------
// Module      : tmp_code_acc
// Description : Temperature-code accumulator. Counts source/sink toggle
//               events over a fixed event window; the number of source
//               events in a completed window is the raw temperature code.
//               Codes go out over a valid/ready handshake with a sticky
//               overrun flag for results dropped while the output was full.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Build option:
//   TMP_CODE_AVG4_EN - when defined, the offered code is the truncated mean of
//                      the last four window results. The first three windows
//                      after reset or abort only fill the history.
//------------------------------------------------------------------------------
// Ports:
//   clk        in   1       system clock (posedge)
//   reset      in   1       asynchronous active-high reset
//   enable     in   1       level; 0 aborts the window and returns to IDLE
//   preChrg    in   1       1 aborts the window and returns to IDLE
//   src_n      in   1       source decision; each toggle is one source event
//   snk        in   1       sink decision; each toggle is one sink event
//   code       out  CODE_W  source count of the last accepted window
//   code_valid out  1       code holds an unconsumed result
//   code_ready in   1       consumer takes code when valid & ready
//   overrun    out  1       sticky: a result was dropped (output full)
//   busy       out  1       high while counting a window
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tmp_code_acc #(
  parameter int WINDOW_LEN = 256,
  parameter int CODE_W     = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              preChrg,
  input  logic              src_n,
  input  logic              snk,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              overrun,
  output logic              busy
);

  // One extra bit so the total can hold the WINDOW_LEN+1 overshoot.
  localparam int              CNT_W = CODE_W + 1;
  localparam logic [CNT_W-1:0] c_WIN = CNT_W'(WINDOW_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_src_q;
  logic                r_snk_q;
  logic [CNT_W-1:0]    r_src_cnt;
  logic [CNT_W-1:0]    r_tot_cnt;
  logic [CODE_W-1:0]   r_snap;
  logic [CODE_W-1:0]   r_code;
  logic                r_code_valid;
  logic                r_overrun;

  logic                w_ev_src;
  logic                w_ev_snk;
  logic                w_abort;
  logic                w_close;
  logic                w_fire;
  logic [CNT_W-1:0]    w_src_add;
  logic [CNT_W-1:0]    w_tot_add;
  logic [CNT_W-1:0]    w_src_sat;
  logic [CODE_W-1:0]   w_result;
  logic                w_offer;

  assign w_ev_src = src_n ^ r_src_q;
  assign w_ev_snk = snk ^ r_snk_q;
  assign w_abort  = !enable || preChrg;

  assign w_src_add = r_src_cnt + CNT_W'(w_ev_src);
  assign w_tot_add = r_tot_cnt + CNT_W'(w_ev_src) + CNT_W'(w_ev_snk);
  assign w_src_sat = (w_src_add > c_WIN) ? c_WIN : w_src_add;

  // A completed window is only delivered if the DONE cycle is not aborted.
  assign w_fire = (r_state == S_DONE) && !w_abort;

  //--------------------------------------------------------------------------
  // FSM state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // FSM next state
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_close     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_abort) begin
          w_state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_tot_add >= c_WIN) begin
          w_state_nxt = S_DONE;
          w_close     = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = w_abort ? S_IDLE : S_COUNT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Edge detectors, event counters and window snapshot.
  // Counters only advance in COUNT; every other state (and the closing
  // cycle itself) leaves them cleared for the next window.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src_q   <= 1'b0;
      r_snk_q   <= 1'b0;
      r_src_cnt <= '0;
      r_tot_cnt <= '0;
      r_snap    <= '0;
    end else begin
      r_src_q <= src_n;
      r_snk_q <= snk;
      if ((r_state == S_COUNT) && !w_abort && !w_close) begin
        r_src_cnt <= w_src_add;
        r_tot_cnt <= w_tot_add;
      end else begin
        r_src_cnt <= '0;
        r_tot_cnt <= '0;
      end
      if (w_close) begin
        r_snap <= CODE_W'(w_src_sat);
      end
    end
  end

  //--------------------------------------------------------------------------
  // Result selection
  //--------------------------------------------------------------------------
`ifdef TMP_CODE_AVG4_EN
  localparam int SUM_W = CODE_W + 2;

  logic [CODE_W-1:0] r_hist0;
  logic [CODE_W-1:0] r_hist1;
  logic [CODE_W-1:0] r_hist2;
  logic [1:0]        r_hist_cnt;
  logic [SUM_W-1:0]  w_sum;

  always_comb begin
    w_sum    = SUM_W'(r_snap) + SUM_W'(r_hist0) + SUM_W'(r_hist1) + SUM_W'(r_hist2);
    w_result = CODE_W'(w_sum >> 2);
    // Three earlier results must be in history before a mean is offered.
    w_offer  = w_fire && (r_hist_cnt == 2'd3);
  end

  // Every completed window enters history, even when its mean is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist0    <= '0;
      r_hist1    <= '0;
      r_hist2    <= '0;
      r_hist_cnt <= 2'd0;
    end else if (w_abort) begin
      r_hist0    <= '0;
      r_hist1    <= '0;
      r_hist2    <= '0;
      r_hist_cnt <= 2'd0;
    end else if (w_fire) begin
      r_hist2 <= r_hist1;
      r_hist1 <= r_hist0;
      r_hist0 <= r_snap;
      if (r_hist_cnt != 2'd3) begin
        r_hist_cnt <= r_hist_cnt + 2'd1;
      end
    end
  end
`else
  assign w_result = r_snap;
  assign w_offer  = w_fire;
`endif

  //--------------------------------------------------------------------------
  // Output holding register and handshake.
  // A load in the DONE cycle takes priority over the consume, so a result
  // accepted in the same cycle keeps code_valid high with the new code.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_offer && (!r_code_valid || code_ready)) begin
        r_code       <= w_result;
        r_code_valid <= 1'b1;
      end else begin
        if (w_offer) begin
          r_overrun <= 1'b1;
        end
        if (r_code_valid && code_ready) begin
          r_code_valid <= 1'b0;
        end
      end
    end
  end

  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign overrun    = r_overrun;
  assign busy       = (r_state == S_COUNT);

endmodule

`default_nettype wire
